// File: rtl/traffic_phase_arbiter.sv
// Actuated phase controller for a T-intersection: main road rests green, side and pedestrian calls latched and granted round-robin.
// Lamps decode directly from the state register; phase timing runs off a free-running prescaled tick.
module traffic_phase_arbiter #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 1,
  parameter int WALK      = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       side_req,
  input  logic       ped_req,
  output logic       main_red,
  output logic       main_yellow,
  output logic       main_green,
  output logic       side_red,
  output logic       side_yellow,
  output logic       side_green,
  output logic       walk,
  output logic       side_pending,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  localparam logic [7:0] MIN_GREEN_M1 = 8'(MIN_GREEN - 1);
  localparam logic [7:0] MAX_GREEN_M1 = 8'(MAX_GREEN - 1);
  localparam logic [7:0] YELLOW_M1    = 8'(YELLOW - 1);
  localparam logic [7:0] ALL_RED_M1   = 8'(ALL_RED - 1);
  localparam logic [7:0] WALK_M1      = 8'(WALK - 1);

  localparam logic GRANT_SIDE = 1'b0;
  localparam logic GRANT_PED  = 1'b1;

  typedef enum logic [2:0] {
    ST_MAIN_GREEN  = 3'd0,
    ST_MAIN_YELLOW = 3'd1,
    ST_MAIN_CLEAR  = 3'd2,
    ST_SIDE_GREEN  = 3'd3,
    ST_SIDE_YELLOW = 3'd4,
    ST_SIDE_CLEAR  = 3'd5,
    ST_PED_WALK    = 3'd6,
    ST_PED_CLEAR   = 3'd7
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [7:0]    timer;
  logic          last_grant;
  logic          enter_side;
  logic          enter_ped;

  assign tick       = (tick_cnt == TICK_LAST);
  assign enter_side = (state_nxt == ST_SIDE_GREEN) && (state != ST_SIDE_GREEN);
  assign enter_ped  = (state_nxt == ST_PED_WALK) && (state != ST_PED_WALK);
  assign phase      = state;

  // Free-running prescaler; state changes never restart it, so every
  // timed interval is an exact multiple of TICK_DIV cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_MAIN_GREEN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer <= 8'd0;
    end else if (state_nxt != state) begin
      timer <= 8'd0;
    end else if (tick && (timer != 8'hFF)) begin
      timer <= timer + 8'd1;
    end
  end

  // Clear wins over a request arriving in the grant cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      side_pending <= 1'b0;
      ped_pending  <= 1'b0;
      last_grant   <= GRANT_PED;
    end else begin
      if (enter_side) begin
        side_pending <= 1'b0;
      end else if (side_req) begin
        side_pending <= 1'b1;
      end
      if (enter_ped) begin
        ped_pending <= 1'b0;
      end else if (ped_req) begin
        ped_pending <= 1'b1;
      end
      if (enter_side) begin
        last_grant <= GRANT_SIDE;
      end else if (enter_ped) begin
        last_grant <= GRANT_PED;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_MAIN_GREEN: begin
        if (tick && (timer >= MIN_GREEN_M1) && (side_pending || ped_pending)) begin
          state_nxt = ST_MAIN_YELLOW;
        end
      end
      ST_MAIN_YELLOW: begin
        if (tick && (timer == YELLOW_M1)) begin
          state_nxt = ST_MAIN_CLEAR;
        end
      end
      ST_MAIN_CLEAR: begin
        if (tick && (timer == ALL_RED_M1)) begin
          if (side_pending && ped_pending) begin
            state_nxt = (last_grant == GRANT_PED) ? ST_SIDE_GREEN : ST_PED_WALK;
          end else if (side_pending) begin
            state_nxt = ST_SIDE_GREEN;
          end else if (ped_pending) begin
            state_nxt = ST_PED_WALK;
          end else begin
            state_nxt = ST_MAIN_GREEN;
          end
        end
      end
      ST_SIDE_GREEN: begin
        if (tick && (((timer >= MIN_GREEN_M1) && (!side_req || ped_pending)) ||
                     (timer == MAX_GREEN_M1))) begin
          state_nxt = ST_SIDE_YELLOW;
        end
      end
      ST_SIDE_YELLOW: begin
        if (tick && (timer == YELLOW_M1)) begin
          state_nxt = ST_SIDE_CLEAR;
        end
      end
      ST_SIDE_CLEAR: begin
        if (tick && (timer == ALL_RED_M1)) begin
          state_nxt = ST_MAIN_GREEN;
        end
      end
      ST_PED_WALK: begin
        if (tick && (timer == WALK_M1)) begin
          state_nxt = ST_PED_CLEAR;
        end
      end
      ST_PED_CLEAR: begin
        if (tick && (timer == ALL_RED_M1)) begin
          state_nxt = ST_MAIN_GREEN;
        end
      end
      default: state_nxt = ST_MAIN_GREEN;
    endcase
  end

  always_comb begin
    main_red    = 1'b0;
    main_yellow = 1'b0;
    main_green  = 1'b0;
    side_red    = 1'b0;
    side_yellow = 1'b0;
    side_green  = 1'b0;
    walk        = 1'b0;
    case (state)
      ST_MAIN_GREEN: begin
        main_green = 1'b1;
        side_red   = 1'b1;
      end
      ST_MAIN_YELLOW: begin
        main_yellow = 1'b1;
        side_red    = 1'b1;
      end
      ST_SIDE_GREEN: begin
        side_green = 1'b1;
        main_red   = 1'b1;
      end
      ST_SIDE_YELLOW: begin
        side_yellow = 1'b1;
        main_red    = 1'b1;
      end
      ST_PED_WALK: begin
        walk     = 1'b1;
        main_red = 1'b1;
        side_red = 1'b1;
      end
      default: begin
        main_red = 1'b1;
        side_red = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Directed bench for traffic_phase_arbiter: expected phase transitions are queued per scenario
// and compared against phase and lamp outputs every cycle.
module tb_traffic_phase_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       side_req;
  logic       ped_req;
  logic       main_red, main_yellow, main_green;
  logic       side_red, side_yellow, side_green;
  logic       walk;
  logic       side_pending, ped_pending;
  logic [2:0] phase;

  traffic_phase_arbiter #(
    .TICK_DIV (4),
    .MIN_GREEN(2),
    .MAX_GREEN(4),
    .YELLOW   (2),
    .ALL_RED  (1),
    .WALK     (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .side_req    (side_req),
    .ped_req     (ped_req),
    .main_red    (main_red),
    .main_yellow (main_yellow),
    .main_green  (main_green),
    .side_red    (side_red),
    .side_yellow (side_yellow),
    .side_green  (side_green),
    .walk        (walk),
    .side_pending(side_pending),
    .ped_pending (ped_pending),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] MG = 3'd0, MY = 3'd1, MC = 3'd2, SG = 3'd3;
  localparam logic [2:0] SY = 3'd4, SC = 3'd5, PW = 3'd6, PC = 3'd7;

  typedef struct {
    int         cyc;
    logic [2:0] ph;
  } tr_t;

  tr_t        sb[$];
  int         cyc;
  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_phase;
  logic [6:0] lamps;

  assign lamps = {main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk};

  // {main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk}
  function automatic logic [6:0] lamp_of(input logic [2:0] ph);
    case (ph)
      MG:      return 7'b0011000;
      MY:      return 7'b0101000;
      SG:      return 7'b1000010;
      SY:      return 7'b1000100;
      PW:      return 7'b1001001;
      default: return 7'b1001000;
    endcase
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic push(input int c, input logic [2:0] p);
    tr_t t;
    t.cyc = c;
    t.ph  = p;
    sb.push_back(t);
  endtask

  task automatic check_cycle();
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_phase = sb[0].ph;
      void'(sb.pop_front());
    end
    chk("phase", int'(phase), int'(exp_phase));
    chk("lamps", int'(lamps), int'(lamp_of(exp_phase)));
  endtask

  task automatic run_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
      check_cycle();
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    side_req = 1'b0;
    ped_req  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    cyc       = 0;
    exp_phase = MG;
    sb.delete();
    chk("rst_side_pending", int'(side_pending), 0);
    chk("rst_ped_pending", int'(ped_pending), 0);
    check_cycle();
  endtask

  task automatic end_scenario();
    chk("sb_left", sb.size(), 0);
  endtask

  initial begin
    // Idle: main road rests green.
    do_reset();
    run_to(200);
    end_scenario();

    // Side request held: side green ends on max green.
    do_reset();
    push(8, MY); push(16, MC); push(20, SG); push(36, SY); push(44, SC); push(48, MG);
    side_req = 1'b1;
    run_to(1);
    chk("side_pend_latched", int'(side_pending), 1);
    run_to(50);
    end_scenario();

    // Pedestrian pulse.
    do_reset();
    push(8, MY); push(16, MC); push(20, PW); push(32, PC); push(36, MG);
    run_to(2);
    ped_req = 1'b1;
    run_to(3);
    ped_req = 1'b0;
    chk("ped_pend_latched", int'(ped_pending), 1);
    run_to(19);
    chk("ped_pend_before_walk", int'(ped_pending), 1);
    run_to(20);
    chk("ped_pend_cleared", int'(ped_pending), 0);
    run_to(40);
    chk("ped_pend_idle", int'(ped_pending), 0);
    end_scenario();

    // Side pulse: latched call survives, min green ends service.
    do_reset();
    push(8, MY); push(16, MC); push(20, SG); push(28, SY); push(36, SC); push(40, MG);
    run_to(1);
    side_req = 1'b1;
    run_to(2);
    side_req = 1'b0;
    chk("side_pend_pulse", int'(side_pending), 1);
    run_to(20);
    chk("side_pend_cleared", int'(side_pending), 0);
    run_to(42);
    end_scenario();

    // Both requesting: round-robin side, ped, side, ped.
    do_reset();
    push(8, MY);   push(16, MC);  push(20, SG);  push(28, SY);  push(36, SC);
    push(40, MG);  push(48, MY);  push(56, MC);  push(60, PW);  push(72, PC);
    push(76, MG);  push(84, MY);  push(92, MC);  push(96, SG);  push(104, SY);
    push(112, SC); push(116, MG); push(124, MY); push(132, MC); push(136, PW);
    push(148, PC); push(152, MG);
    side_req = 1'b1;
    ped_req  = 1'b1;
    run_to(1);
    side_req = 1'b0;
    ped_req  = 1'b0;
    run_to(21);
    side_req = 1'b1;
    run_to(22);
    side_req = 1'b0;
    run_to(61);
    ped_req = 1'b1;
    run_to(62);
    ped_req = 1'b0;
    run_to(97);
    side_req = 1'b1;
    run_to(98);
    side_req = 1'b0;
    run_to(155);
    end_scenario();

    // Reset during side green, then full replay of the held-side sequence.
    do_reset();
    push(8, MY); push(16, MC); push(20, SG);
    side_req = 1'b1;
    run_to(24);
    end_scenario();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n   = 1'b1;
    cyc       = 0;
    exp_phase = MG;
    chk("mid_rst_side_pending", int'(side_pending), 0);
    chk("mid_rst_ped_pending", int'(ped_pending), 0);
    check_cycle();
    push(8, MY); push(16, MC); push(20, SG); push(36, SY); push(44, SC); push(48, MG);
    run_to(50);
    end_scenario();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
